uart_cmd_parser: RTL

- Sits directly downstream of the UART receiver: consumes its byte-ready level and 8-bit data, and assembles fixed-format command frames.
- Each frame is a sync byte, a channel, a 16-bit delay and an optional checksum.
- On a good frame, issues a one-cycle write strobe with channel and delay to the delay register bank.
- On a bad frame, issues a one-cycle error strobe with a cause code.

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_cmd_parser_sync.sv | 13 +
 rtl/uart_cmd_parser.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding, error codes and frame constants for uart_cmd_parser.
// Frame length depends on CMD_CHECKSUM_EN.
package uart_cmd_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHAN = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_CHAN = S_CHAN,
    ST_DHI  = S_DHI,
    ST_DLO  = S_DLO,
    ST_CSUM = S_CSUM
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int FRAME_LEN_BASE = 4;
  localparam int FRAME_LEN_CSUM = 5;
`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  function automatic logic [7:0] frame_csum(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo);
    return ch ^ hi ^ lo;
  endfunction
endpackage

// File: rtl/uart_cmd_parser_sync.sv
// sync_rise_detect: 2-FF synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);
  logic [2:0] r_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_level};
  assign o_rise = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles sync/channel/delay[/checksum] frames from a UART byte stream.
// Define CMD_CHECKSUM_EN for the 5-byte checksummed frame; default is the 4-byte frame.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         CHANNEL_COUNT  = 16,
  parameter int         CHANNEL_WIDTH  = $clog2(CHANNEL_COUNT),
  parameter int         TIMEOUT_CYCLES = 104_166
) (
  input  logic                     clockIN,
  input  logic                     nResetIN,
  input  logic                     rxReadyIN,
  input  logic [7:0]               rxDataIN,
  output logic                     cmdValidOUT,
  output logic [CHANNEL_WIDTH-1:0] cmdChannelOUT,
  output logic [15:0]              cmdDelayOUT,
  output logic                     errValidOUT,
  output logic [1:0]               errCodeOUT,
  output logic                     busyOUT
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
`ifdef CMD_CHECKSUM_EN
  localparam state_t ST_LAST = ST_CSUM;
`else
  localparam state_t ST_LAST = ST_DLO;
`endif
  state_t                   r_state;
  logic [7:0]               r_chan;
  logic [7:0]               r_hi;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_cmd_valid;
  logic [CHANNEL_WIDTH-1:0] r_cmd_chan;
  logic [15:0]              r_cmd_delay;
  logic                     r_err_valid;
  logic [1:0]               r_err_code;
  logic                     w_stb;
  logic                     w_tmo;
  logic                     w_range_bad;
  logic                     w_csum_bad;
  logic [15:0]              w_delay;
  sync_rise_detect u_sync (
    .clk    (clockIN),
    .rst_n  (nResetIN),
    .i_level(rxReadyIN),
    .o_rise (w_stb)
  );
`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_lo;
  assign w_csum_bad = rxDataIN != frame_csum(r_chan, r_hi, r_lo);
  assign w_delay    = {r_hi, r_lo};
`else
  assign w_csum_bad = 1'b0;
  assign w_delay    = {r_hi, rxDataIN};
`endif
  assign w_tmo       = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_range_bad = {1'b0, r_chan} >= 9'(CHANNEL_COUNT);
  // A byte arriving on the terminal count wins over the timeout.
  always_ff @(posedge clockIN or negedge nResetIN)
    if (!nResetIN) begin
      r_state     <= ST_IDLE;
      r_chan      <= '0;
      r_hi        <= '0;
`ifdef CMD_CHECKSUM_EN
      r_lo        <= '0;
`endif
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_chan  <= '0;
      r_cmd_delay <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_cmd_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_cnt       <= (r_state == ST_IDLE || w_stb) ? '0 : r_cnt + 1'b1;
      if (w_stb) begin
        case (r_state)
          ST_IDLE: r_state <= (rxDataIN == SYNC_BYTE) ? ST_CHAN : ST_IDLE;
          ST_CHAN: begin
            r_chan  <= rxDataIN;
            r_state <= ST_DHI;
          end
          ST_DHI: begin
            r_hi    <= rxDataIN;
            r_state <= ST_DLO;
          end
`ifdef CMD_CHECKSUM_EN
          ST_DLO: begin
            r_lo    <= rxDataIN;
            r_state <= ST_CSUM;
          end
`endif
          ST_LAST: begin
            r_state <= ST_IDLE;
            if (w_csum_bad) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_CSUM;
            end else if (w_range_bad) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_RANGE;
            end else begin
              r_cmd_valid <= 1'b1;
              r_cmd_chan  <= r_chan[CHANNEL_WIDTH-1:0];
              r_cmd_delay <= w_delay;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_tmo) begin
        r_state     <= ST_IDLE;
        r_err_valid <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
      end
    end
  assign cmdValidOUT   = r_cmd_valid;
  assign cmdChannelOUT = r_cmd_chan;
  assign cmdDelayOUT   = r_cmd_delay;
  assign errValidOUT   = r_err_valid;
  assign errCodeOUT    = r_err_code;
  assign busyOUT       = r_state != ST_IDLE;
endmodule
